// File: rtl/stencil_engine.sv
// stencil_engine: 2-D 5-point explicit heat-diffusion engine over a register-held grid.
// Build option STENCIL_JACOBI_EN: double-buffered Jacobi sweeps; default is in-place Gauss-Seidel.
module stencil_engine #(
   parameter int GRID_W = 4,
   parameter int GRID_H = 4,
   parameter int DW     = 4,
   parameter int AW     = $clog2(GRID_W * GRID_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] sweep_cnt
);
   localparam int N  = GRID_W * GRID_H;
   localparam int CW = $clog2(GRID_W);
   localparam int RW = $clog2(GRID_H);
   localparam int LW = DW + 4;
   localparam logic signed [LW-1:0] MAXS = LW'((1 << DW) - 1);
   localparam logic [1:0] OP_RUN = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_CONFIG = 2'b11;
`ifdef STENCIL_JACOBI_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   typedef enum logic {IDLE, SWEEP} state_t;
   state_t state_reg, state_next;

   logic [DW-1:0] cell_reg [NB][N];
   logic [RW-1:0] row_reg;
   logic [CW-1:0] col_reg;
   logic [AW-1:0] sweep_cnt_reg;
   logic [DW-1:0] rd_data_reg, boundary_reg;
   logic [1:0]    alpha_reg;
   logic          rd_valid_reg, done_reg, periodic_reg;
   logic          rbank, wbank;

`ifdef STENCIL_JACOBI_EN
   logic bank_reg;
   assign rbank = bank_reg;
   assign wbank = ~bank_reg;
`else
   assign rbank = 1'b0;
   assign wbank = 1'b0;
`endif

   function automatic logic [AW-1:0] cell_index(input int r, input int c);
      return AW'(r * GRID_W + c);
   endfunction

   logic                 accept, last_cell, addr_ok;
   logic [AW-1:0]        cur_idx;
   logic [DW-1:0]        c_v, n_v, s_v, e_v, w_v, new_v;
   logic signed [LW-1:0] lap, delta, sum_v;
   logic [2:0]           shamt;

   assign cmd_ready = (state_reg == IDLE) && rst_n;
   assign accept    = cmd_valid && cmd_ready;
   assign addr_ok   = int'(cmd_addr) < N;
   assign last_cell = (row_reg == RW'(GRID_H - 1)) && (col_reg == CW'(GRID_W - 1));
   assign busy      = (state_reg == SWEEP);
   assign done      = done_reg;
   assign rd_data   = rd_data_reg;
   assign rd_valid  = rd_valid_reg;
   assign sweep_cnt = sweep_cnt_reg;

   // Neighbour fetch: edge cells see either the wrapped cell or the boundary value.
   always_comb begin
      cur_idx = cell_index(int'(row_reg), int'(col_reg));
      c_v     = cell_reg[rbank][cur_idx];
      if (row_reg == '0)
         n_v = periodic_reg ? cell_reg[rbank][cell_index(GRID_H - 1, int'(col_reg))] : boundary_reg;
      else
         n_v = cell_reg[rbank][cell_index(int'(row_reg) - 1, int'(col_reg))];
      if (row_reg == RW'(GRID_H - 1))
         s_v = periodic_reg ? cell_reg[rbank][cell_index(0, int'(col_reg))] : boundary_reg;
      else
         s_v = cell_reg[rbank][cell_index(int'(row_reg) + 1, int'(col_reg))];
      if (col_reg == '0)
         w_v = periodic_reg ? cell_reg[rbank][cell_index(int'(row_reg), GRID_W - 1)] : boundary_reg;
      else
         w_v = cell_reg[rbank][cell_index(int'(row_reg), int'(col_reg) - 1)];
      if (col_reg == CW'(GRID_W - 1))
         e_v = periodic_reg ? cell_reg[rbank][cell_index(int'(row_reg), 0)] : boundary_reg;
      else
         e_v = cell_reg[rbank][cell_index(int'(row_reg), int'(col_reg) + 1)];

      lap   = LW'(n_v) + LW'(s_v) + LW'(e_v) + LW'(w_v) - (LW'(c_v) << 2);
      shamt = {1'b0, alpha_reg} + 3'd2;
      delta = lap >>> shamt;
      sum_v = LW'(c_v) + delta;
      if (sum_v < 0)
         new_v = '0;
      else if (sum_v > MAXS)
         new_v = '1;
      else
         new_v = DW'(sum_v);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept && cmd_op == OP_RUN && cmd_addr != '0) state_next = SWEEP;
         SWEEP:   if (last_cell && sweep_cnt_reg == AW'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         row_reg       <= '0;
         col_reg       <= '0;
         sweep_cnt_reg <= '0;
         rd_data_reg   <= '0;
         rd_valid_reg  <= 1'b0;
         done_reg      <= 1'b0;
         alpha_reg     <= '0;
         periodic_reg  <= 1'b0;
         boundary_reg  <= '0;
`ifdef STENCIL_JACOBI_EN
         bank_reg      <= 1'b0;
`endif
         for (int b = 0; b < NB; b++)
            for (int i = 0; i < N; i++)
               cell_reg[b][i] <= '0;
      end else begin
         state_reg    <= state_next;
         rd_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         if (state_reg == IDLE) begin
            if (accept) begin
               case (cmd_op)
                  OP_RUN: begin
                     if (cmd_addr == '0) begin
                        done_reg <= 1'b1;
                     end else begin
                        sweep_cnt_reg <= cmd_addr;
                        row_reg       <= '0;
                        col_reg       <= '0;
                     end
                  end
                  OP_WRITE: if (addr_ok) cell_reg[rbank][cmd_addr] <= cmd_data;
                  OP_READ: begin
                     rd_data_reg  <= addr_ok ? cell_reg[rbank][cmd_addr] : '0;
                     rd_valid_reg <= 1'b1;
                  end
                  default: begin
                     alpha_reg    <= cmd_addr[1:0];
                     periodic_reg <= cmd_addr[2];
                     boundary_reg <= cmd_data;
                  end
               endcase
            end
         end else begin
            cell_reg[wbank][cur_idx] <= new_v;
            if (last_cell) begin
               row_reg       <= '0;
               col_reg       <= '0;
               sweep_cnt_reg <= sweep_cnt_reg - 1'b1;
               if (sweep_cnt_reg == AW'(1)) done_reg <= 1'b1;
`ifdef STENCIL_JACOBI_EN
               bank_reg <= ~bank_reg;
`endif
            end else if (col_reg == CW'(GRID_W - 1)) begin
               col_reg <= '0;
               row_reg <= row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_stencil_engine.sv
// Self-checking bench for stencil_engine: random grids checked against an array-based diffusion model.
module tb_stencil_engine;
   localparam int W = 4, H = 4, DW = 4, N = W * H, AW = $clog2(N);
   localparam int OP_RUN = 0, OP_WRITE = 1, OP_READ = 2, OP_CONFIG = 3;

   logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          cmd_ready, rd_valid, busy, done;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] sweep_cnt;

   int checks = 0, errors = 0;
   int m_grid[N];
   int m_alpha = 0, m_periodic = 0, m_boundary = 0;
   int cnt_seq[$];

   stencil_engine #(.GRID_W(W), .GRID_H(H), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int floor_div(input int x, input int d);
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   function automatic int get_cell(input int g[N], input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) begin
         if (m_periodic == 0) return m_boundary;
         return g[((r + H) % H) * W + ((c + W) % W)];
      end
      return g[r * W + c];
   endfunction

   task automatic model_sweeps(input int n);
      int src[N];
      int lap, v;
      for (int k = 0; k < n; k++) begin
         src = m_grid;
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
`ifndef STENCIL_JACOBI_EN
               src = m_grid;
`endif
               lap = get_cell(src, r - 1, c) + get_cell(src, r + 1, c)
                   + get_cell(src, r, c - 1) + get_cell(src, r, c + 1) - 4 * src[r * W + c];
               v = src[r * W + c] + floor_div(lap, 4 << m_alpha);
               if (v < 0) v = 0;
               if (v > (1 << DW) - 1) v = (1 << DW) - 1;
               m_grid[r * W + c] = v;
            end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_grid[i] = 0;
      m_alpha = 0; m_periodic = 0; m_boundary = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic send(input int op, input int addr, input int data);
      int w = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 300) begin
         errors++;
         $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_addr  = AW'(addr);
      cmd_data  = DW'(data);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic read_cell(input int addr, output logic [DW-1:0] d, output logic v);
      send(OP_READ, addr, 0);
      d = rd_data;
      v = rd_valid;
   endtask

   task automatic set_config(input int alpha, input int per, input int bnd);
      send(OP_CONFIG, per * 4 + alpha, bnd);
      m_alpha = alpha; m_periodic = per; m_boundary = bnd;
   endtask

   task automatic load_grid(input int fixed, input int use_random);
      for (int i = 0; i < N; i++) begin
         m_grid[i] = use_random ? int'($urandom_range(0, (1 << DW) - 1)) : fixed;
         send(OP_WRITE, i, m_grid[i]);
      end
   endtask

   task automatic do_run(input int n, output int cyc);
      send(OP_RUN, n, 0);
      cyc = 0;
      cnt_seq.delete();
      cnt_seq.push_back(int'(sweep_cnt));
      while (done !== 1'b1 && cyc < n * N + 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (int'(sweep_cnt) != cnt_seq[$]) cnt_seq.push_back(int'(sweep_cnt));
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [DW-1:0] d;
      logic v;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b required 0", cmd_ready); end
      rst_n = 1'b1;
      #1;
      model_reset();
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
      checks++;
      if ({busy, done, rd_valid} !== 3'b000 || sweep_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b rd_valid=%b sweep_cnt=%0d required all 0", busy, done, rd_valid, sweep_cnt);
      end
      read_cell(5, d, v);
      checks++;
      if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL reset_read5: valid=%b data=%0d required 1/0", v, d); end
   endtask

   task automatic test_single_sweep();
      logic [DW-1:0] d;
      logic v;
      int cyc;
      int exp1;
`ifdef STENCIL_JACOBI_EN
      exp1 = 3;
`else
      exp1 = 5;
`endif
      set_config(0, 0, 15);
      load_grid(0, 0);
      do_run(1, cyc);
      model_sweeps(1);
      checks++;
      if (cyc != 16 || done !== 1'b1) begin errors++; $display("FAIL single_latency: got %0d cycles (done=%b) required 16", cyc, done); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done_width: done=%b busy=%b required 0/0", done, busy); end
      read_cell(0, d, v);
      checks++;
      if (v !== 1'b1 || d !== 4'd7) begin errors++; $display("FAIL single_cell0: got %0d required 7", d); end
      read_cell(1, d, v);
      checks++;
      if (v !== 1'b1 || d !== DW'(exp1)) begin errors++; $display("FAIL single_cell1: got %0d required %0d", d, exp1); end
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== DW'(m_grid[i])) begin errors++; $display("FAIL single_grid[%0d]: got %0d required %0d", i, d, m_grid[i]); end
      end
   endtask

   task automatic test_steady_state();
      logic [DW-1:0] d;
      logic v;
      int cyc;
      int ok;
      set_config(0, 0, 5);
      load_grid(5, 0);
      do_run(10, cyc);
      model_sweeps(10);
      checks++;
      if (cyc != 160) begin errors++; $display("FAIL steady_latency: got %0d cycles required 160", cyc); end
      ok = (cnt_seq.size() == 11);
      for (int i = 0; i < cnt_seq.size() && ok != 0; i++) if (cnt_seq[i] != 10 - i) ok = 0;
      checks++;
      if (ok == 0) begin errors++; $display("FAIL steady_sweep_cnt: got %0d distinct values from %0d required 10..0", cnt_seq.size(), cnt_seq[0]); end
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== 4'd5) begin errors++; $display("FAIL steady_grid[%0d]: got %0d required 5", i, d); end
      end
   endtask

   task automatic test_periodic();
      logic [DW-1:0] d;
      logic v;
      int cyc;
      set_config(1, 1, 0);
      load_grid(9, 0);
      do_run(3, cyc);
      model_sweeps(3);
      checks++;
      if (cyc != 48) begin errors++; $display("FAIL periodic_latency: got %0d required 48", cyc); end
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== 4'd9) begin errors++; $display("FAIL periodic_grid[%0d]: got %0d required 9", i, d); end
      end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] d;
      logic v;
      int cyc;
      set_config(0, 0, 15);
      load_grid(15, 0);
      do_run(2, cyc);
      model_sweeps(2);
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== 4'd15) begin errors++; $display("FAIL saturation_grid[%0d]: got %0d required 15", i, d); end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      logic v;
      int cyc, n;
      for (int it = 0; it < 6; it++) begin
         set_config(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         load_grid(0, 1);
         n = int'($urandom_range(1, 3));
         do_run(n, cyc);
         model_sweeps(n);
         checks++;
         if (cyc != n * N) begin errors++; $display("FAIL random%0d_latency: got %0d required %0d", it, cyc, n * N); end
         for (int i = 0; i < N; i++) begin
            read_cell(i, d, v);
            checks++;
            if (v !== 1'b1 || d !== DW'(m_grid[i])) begin
               errors++;
               $display("FAIL random%0d_grid[%0d]: got %0d required %0d (alpha=%0d periodic=%0d bnd=%0d)",
                        it, i, d, m_grid[i], m_alpha, m_periodic, m_boundary);
            end
         end
      end
   endtask

   task automatic test_busy_write();
      logic [DW-1:0] d;
      logic v;
      int k;
      logic ready_seen;
      set_config(1, 0, 3);
      load_grid(0, 1);
      send(OP_RUN, 3, 0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'(OP_WRITE);
      cmd_addr  = AW'(3);
      cmd_data  = DW'(15 - m_grid[3]);
      ready_seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (ready_seen !== 1'b0) begin errors++; $display("FAIL busy_ready: cmd_ready high or busy low during sweep, required 0/1"); end
      k = 0;
      while (done !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL busy_done_timeout: done=%b required 1", done); end
      model_sweeps(3);
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== DW'(m_grid[i])) begin errors++; $display("FAIL busy_grid[%0d]: got %0d required %0d", i, d, m_grid[i]); end
      end
   endtask

   task automatic test_abort();
      logic [DW-1:0] d;
      logic v;
      logic saw_done;
      set_config(0, 0, 15);
      load_grid(0, 1);
      send(OP_RUN, 5, 0);
      saw_done = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== '0) begin
         errors++;
         $display("FAIL abort_outputs: busy=%b done=%b sweep_cnt=%0d required 0/0/0", busy, done, sweep_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (20) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: done pulse seen, required none"); end
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL abort_grid[%0d]: got %0d required 0", i, d); end
      end
   endtask

   task automatic test_run_zero();
      logic [DW-1:0] d;
      logic v;
      int cyc;
      set_config(2, 1, 7);
      load_grid(0, 1);
      do_run(0, cyc);
      checks++;
      if (cyc != 0 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL run0_done: cycles=%0d done=%b busy=%b required 0/1/0", cyc, done, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL run0_done_width: got %b required 0", done); end
      for (int i = 0; i < N; i++) begin
         read_cell(i, d, v);
         checks++;
         if (v !== 1'b1 || d !== DW'(m_grid[i])) begin errors++; $display("FAIL run0_grid[%0d]: got %0d required %0d", i, d, m_grid[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_sweep();
      test_steady_state();
      test_periodic();
      test_saturation();
      test_random();
      test_busy_write();
      test_abort();
      test_run_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
